// File: rtl/bus_pkg.sv
// Shared types for the 68000 bus sequencer: FSM states, address regions,
// the address-map nibbles and the registered output bundle.
package bus_pkg;

  typedef enum logic [2:0] {IDLE, WAIT, ACK, PERIPH, TOUT, ERR} state_t;

  typedef enum logic [2:0] {
    REG_ROM, REG_RAM, REG_LED, REG_ACIA, REG_GPIO, REG_NONE
  } region_t;

  // Address map on addr[15:12]; addr[23:16] is not decoded, so regions mirror.
  localparam logic [3:0] NIB_ROM  = 4'h0;
  localparam logic [3:0] NIB_RAM  = 4'h1;
  localparam logic [3:0] NIB_LED  = 4'h2;
  localparam logic [3:0] NIB_ACIA = 4'h3;
  localparam logic [3:0] NIB_GPIO = 4'h4;

  typedef struct packed {
    logic       dtack_n;
    logic       vpa_n;
    logic       berr_n;
    logic       rom_cs;
    logic       ram_cs;
    logic       ram_we;
    logic [1:0] ram_mask;
    logic       led_cs;
    logic       acia_cs;
    logic       gpio_cs;
  } bus_out_t;

  localparam bus_out_t OUT_IDLE = '{dtack_n: 1'b1, vpa_n: 1'b1, berr_n: 1'b1, default: '0};

endpackage

// File: rtl/bus_decode.sv
// Combinational region decode of addr[15:12]; the single definition of the map.
module bus_decode
  import bus_pkg::*;
(
  input  logic [3:0] nibble,
  output region_t    region
);

  always_comb begin
    case (nibble)
      NIB_ROM:  region = REG_ROM;
      NIB_RAM:  region = REG_RAM;
      NIB_LED:  region = REG_LED;
      NIB_ACIA: region = REG_ACIA;
      NIB_GPIO: region = REG_GPIO;
      default:  region = REG_NONE;
    endcase
  end

endmodule

// File: rtl/bus_ctrl.sv
// 68000 bus-cycle sequencer: decodes each AS cycle, drives registered selects
// and terminates it with DTACKn (ROM/RAM), VPAn (peripherals) or BERRn (timeout).
module bus_ctrl
  import bus_pkg::*;
#(
  parameter int unsigned ROM_WAIT = 0,
  parameter int unsigned RAM_WAIT = 0,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        as_n,
  input  logic        rw,
  input  logic        uds_n,
  input  logic        lds_n,
  input  logic        vma_n,
  input  logic [23:1] addr,
  output logic        dtack_n,
  output logic        vpa_n,
  output logic        berr_n,
  output logic        rom_cs,
  output logic        ram_cs,
  output logic        ram_we,
  output logic [1:0]  ram_mask,
  output logic        led_cs,
  output logic        acia_cs,
  output logic        gpio_cs
);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  region_t    region_q, region_d;
  logic       rw_q, rw_d;
  logic [1:0] mask_d;
  bus_out_t   outs_q, outs_d;
  region_t    dec_region;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[23:16], addr[11:1]};

  bus_decode u_decode (
    .nibble (addr[15:12]),
    .region (dec_region)
  );

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    cnt_d    = cnt_q;
    region_d = region_q;
    rw_d     = rw_q;
    mask_d   = outs_q.ram_mask;

    case (state_q)
      IDLE: begin
        if (!as_n) begin
          region_d = dec_region;
          rw_d     = rw;
          mask_d   = {~uds_n, ~lds_n};
          case (dec_region)
            REG_ROM: begin
              cnt_d   = 8'(ROM_WAIT);
              state_d = WAIT;
            end
            REG_RAM: begin
              cnt_d   = 8'(RAM_WAIT);
              state_d = WAIT;
            end
            REG_NONE: begin
              cnt_d   = 8'(TIMEOUT - 1);
              state_d = TOUT;
            end
            default: state_d = PERIPH;
          endcase
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = ACK;
        else             cnt_d   = cnt_q - 8'd1;
      end
      TOUT: begin
        if (cnt_q == '0) state_d = ERR;
        else             cnt_d   = cnt_q - 8'd1;
      end
      default: ;
    endcase

    // A released strobe ends any cycle, including aborts and CPU reset.
    if (state_q != IDLE && as_n) state_d = IDLE;

    // Outputs are decoded from the next state so they appear registered.
    outs_d = OUT_IDLE;
    if (state_d != IDLE) begin
      outs_d.ram_mask = mask_d;
      outs_d.dtack_n  = (state_d != ACK);
      outs_d.vpa_n    = (state_d != PERIPH);
      outs_d.berr_n   = (state_d != ERR);
      outs_d.rom_cs   = (state_d inside {WAIT, ACK}) && (region_d == REG_ROM);
      outs_d.ram_cs   = (state_d inside {WAIT, ACK}) && (region_d == REG_RAM);
      outs_d.ram_we   = (state_q == WAIT) && (state_d == ACK) &&
                        (region_d == REG_RAM) && !rw_d;
      outs_d.led_cs   = (state_d == PERIPH) && (region_d == REG_LED)  && !vma_n;
      outs_d.acia_cs  = (state_d == PERIPH) && (region_d == REG_ACIA) && !vma_n;
      outs_d.gpio_cs  = (state_d == PERIPH) && (region_d == REG_GPIO) && !vma_n;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      region_q <= REG_NONE;
      rw_q     <= 1'b1;
      outs_q   <= OUT_IDLE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      region_q <= region_d;
      rw_q     <= rw_d;
      outs_q   <= outs_d;
    end
  end

  assign dtack_n  = outs_q.dtack_n;
  assign vpa_n    = outs_q.vpa_n;
  assign berr_n   = outs_q.berr_n;
  assign rom_cs   = outs_q.rom_cs;
  assign ram_cs   = outs_q.ram_cs;
  assign ram_we   = outs_q.ram_we;
  assign ram_mask = outs_q.ram_mask;
  assign led_cs   = outs_q.led_cs;
  assign acia_cs  = outs_q.acia_cs;
  assign gpio_cs  = outs_q.gpio_cs;

endmodule
